// File: rtl/step_gen_pkg.sv
// step_gen_pkg: shared types and constants for the step enable generator.
// State encoding, default parameters and counter widths.
package step_gen_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  localparam int unsigned DEF_DEBOUNCE      = 16;
  localparam int unsigned DEF_REPEAT_DELAY  = 50000000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10000000;

  localparam int DB_W  = 16;
  localparam int RPT_W = 32;
  localparam int CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous level.
// Both flops clear to 0 on asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // shift the raw level through two flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_enable_gen.sv
// step_enable_gen: debounced push-button to one-cycle step enable.
// Optional auto-repeat is built when STEP_AUTO_REPEAT_EN is defined.
module step_enable_gen
  import step_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             hold,
  output logic             step,
  output logic             btn_db,
  output logic [CNT_W-1:0] step_cnt
);

  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

  state_t          state;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_nxt;
  logic            btn_s;
  logic            entry_fire;
  logic            rpt_fire;
  logic            fire;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  // press accepted on the edge the counter reaches its limit
  always_comb begin
    db_nxt     = db_cnt + 1'b1;
    entry_fire = (state == DB_PRESS) && btn_s
                 && (db_nxt == DB_MAX);
    fire       = entry_fire || rpt_fire;
  end

`ifdef STEP_AUTO_REPEAT_EN
  localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_nxt;
  logic [RPT_W-1:0] rpt_lim;
  logic             rpt_first;
  logic             rpt_act;

  // first repeat waits the long delay, later ones the period
  always_comb begin
    rpt_act  = (state == PRESSED) || (state == DB_RELEASE);
    rpt_nxt  = rpt_cnt + 1'b1;
    rpt_lim  = rpt_first ? RPT_DLY : RPT_PER;
    rpt_fire = rpt_act && (rpt_nxt == rpt_lim);
  end

  // repeat timer runs regardless of hold; cleared outside a press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (entry_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else if (rpt_act) begin
      rpt_cnt   <= rpt_nxt;
    end else begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // debounce FSM with registered step, level and pulse count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      db_cnt   <= '0;
      step     <= 1'b0;
      btn_db   <= 1'b0;
      step_cnt <= '0;
    end else begin
      step <= 1'b0;
      if (fire && !hold) begin
        step     <= 1'b1;
        step_cnt <= step_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state  <= DB_PRESS;
            db_cnt <= DB_W'(1);
          end
        end
        DB_PRESS: begin
          if (!btn_s) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (db_nxt == DB_MAX) begin
            state  <= PRESSED;
            db_cnt <= '0;
            btn_db <= 1'b1;
          end else begin
            db_cnt <= db_nxt;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state  <= DB_RELEASE;
            db_cnt <= DB_W'(1);
          end
        end
        DB_RELEASE: begin
          if (btn_s) begin
            state  <= PRESSED;
            db_cnt <= '0;
          end else if (db_nxt == DB_MAX) begin
            state  <= IDLE;
            db_cnt <= '0;
            btn_db <= 1'b0;
          end else begin
            db_cnt <= db_nxt;
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_enable_gen.sv
// tb_step_enable_gen: directed bench for step_enable_gen.
// Debounce, hold, wrap, reset abort and optional auto-repeat.
module tb_step_enable_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       hold;
  logic       step;
  logic       btn_db;
  logic [7:0] step_cnt;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int dbl    = 0;
  logic step_prev = 1'b0;

  always #5 clk = ~clk;

  step_enable_gen #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .hold     (hold),
    .step     (step),
    .btn_db   (btn_db),
    .step_cnt (step_cnt)
  );

`ifdef STEP_AUTO_REPEAT_EN
  logic       btn_r;
  logic       hold_r;
  logic       step_r;
  logic       btn_db_r;
  logic [7:0] step_cnt_r;

  step_enable_gen #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut_r (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_r),
    .hold     (hold_r),
    .step     (step_r),
    .btn_db   (btn_db_r),
    .step_cnt (step_cnt_r)
  );
`endif

  always @(posedge clk) begin
    if (step) pulses = pulses + 1;
    if (step && step_prev) dbl = dbl + 1;
    step_prev = step;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int n);
    btn_in = 1'b1;
    settle(n);
    btn_in = 1'b0;
    settle(12);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    settle(3);
    total++;
    if (step !== 1'b0) begin
      bad++;
      $display("FAIL reset_step got=%b want=0", step);
    end
    total++;
    if (btn_db !== 1'b0) begin
      bad++;
      $display("FAIL reset_btn_db got=%b want=0", btn_db);
    end
    total++;
    if (step_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d want=0", step_cnt);
    end
    rst = 1'b1;
    settle(2);
  endtask

  task automatic test_clean_press();
    btn_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if (step !== (i == 6)) begin
        bad++;
        $display("FAIL clean_step edge=%0d got=%b want=%b",
                 i, step, (i == 6));
      end
    end
    total++;
    if (btn_db !== 1'b1) begin
      bad++;
      $display("FAIL clean_btn_db got=%b want=1", btn_db);
    end
    total++;
    if (step_cnt !== 8'd1) begin
      bad++;
      $display("FAIL clean_cnt got=%0d want=1", step_cnt);
    end
    btn_in = 1'b0;
    settle(12);
    total++;
    if (btn_db !== 1'b0) begin
      bad++;
      $display("FAIL clean_release got=%b want=0", btn_db);
    end
  endtask

  task automatic test_bounce();
    for (int k = 1; k <= 20; k++) begin
      btn_in = (k <= 3) || (k >= 5);
      tick();
      total++;
      if (step !== (k == 10)) begin
        bad++;
        $display("FAIL bounce_step edge=%0d got=%b want=%b",
                 k, step, (k == 10));
      end
    end
    total++;
    if (step_cnt !== 8'd2) begin
      bad++;
      $display("FAIL bounce_cnt got=%0d want=2", step_cnt);
    end
    btn_in = 1'b0;
    settle(12);
  endtask

  task automatic test_glitch();
    btn_in = 1'b1;
    settle(3);
    btn_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (step !== 1'b0 || btn_db !== 1'b0) begin
        bad++;
        $display("FAIL glitch step=%b btn_db=%b want=0,0",
                 step, btn_db);
      end
    end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    btn_in = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      total++;
      if (step !== 1'b0) begin
        bad++;
        $display("FAIL hold_step edge=%0d got=%b want=0",
                 i, step);
      end
    end
    total++;
    if (btn_db !== 1'b1) begin
      bad++;
      $display("FAIL hold_btn_db got=%b want=1", btn_db);
    end
    btn_in = 1'b0;
    settle(12);
    total++;
    if (btn_db !== 1'b0) begin
      bad++;
      $display("FAIL hold_release got=%b want=0", btn_db);
    end
    total++;
    if (step_cnt !== 8'd2) begin
      bad++;
      $display("FAIL hold_cnt got=%0d want=2", step_cnt);
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_mid();
    btn_in = 1'b1;
    settle(4);
    rst = 1'b0;
    #1;
    total++;
    if ({step, btn_db, step_cnt} !== 10'd0) begin
      bad++;
      $display("FAIL rstmid_out step=%b db=%b cnt=%0d want=0",
               step, btn_db, step_cnt);
    end
    settle(2);
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      total++;
      if (step !== (i == 6)) begin
        bad++;
        $display("FAIL rstmid_step edge=%0d got=%b want=%b",
                 i, step, (i == 6));
      end
    end
    total++;
    if (step_cnt !== 8'd1) begin
      bad++;
      $display("FAIL rstmid_cnt got=%0d want=1", step_cnt);
    end
    btn_in = 1'b0;
    settle(12);
  endtask

  task automatic test_wrap();
    int p0;
    rst = 1'b0;
    settle(1);
    rst = 1'b1;
    settle(1);
    p0 = pulses;
    for (int n = 1; n <= 256; n++) begin
      press(10);
      if (n == 255) begin
        total++;
        if (step_cnt !== 8'd255) begin
          bad++;
          $display("FAIL wrap_255 got=%0d want=255", step_cnt);
        end
      end
    end
    total++;
    if (step_cnt !== 8'd0) begin
      bad++;
      $display("FAIL wrap_cnt got=%0d want=0", step_cnt);
    end
    total++;
    if (pulses - p0 !== 256) begin
      bad++;
      $display("FAIL wrap_pulses got=%0d want=256", pulses - p0);
    end
  endtask

  task automatic test_back_to_back();
    total++;
    if (dbl !== 0) begin
      bad++;
      $display("FAIL back_to_back got=%0d want=0", dbl);
    end
  endtask

`ifdef STEP_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int rel;
    logic want;
    btn_r = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      rel = k - 6;
      want = (rel == 0) || (rel == 10) || (rel == 15)
             || (rel == 20) || (rel == 25) || (rel == 30);
      total++;
      if (step_r !== want) begin
        bad++;
        $display("FAIL repeat_step rel=%0d got=%b want=%b",
                 rel, step_r, want);
      end
      if (rel == 28) btn_r = 1'b0;
    end
    total++;
    if (btn_db_r !== 1'b0) begin
      bad++;
      $display("FAIL repeat_btn_db got=%b want=0", btn_db_r);
    end
    total++;
    if (step_cnt_r !== 8'd6) begin
      bad++;
      $display("FAIL repeat_cnt got=%0d want=6", step_cnt_r);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    btn_in = 1'b0;
    hold = 1'b0;
`ifdef STEP_AUTO_REPEAT_EN
    btn_r = 1'b0;
    hold_r = 1'b0;
`endif
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_hold();
    test_reset_mid();
`ifdef STEP_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
